// File: rtl/cpu_bus.sv
// CPU-side bus responder: captures CPU requests, decodes them into RAM / PPU / PRG / unmapped
// regions and returns read data (or write completion) with a combinational data-valid gate.
module cpu_bus #(
  parameter int unsigned RAM_WAIT_STATES = 1,
  parameter int unsigned EXT_TIMEOUT     = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] cpu_address_i,
  input  logic        cpu_address_valid_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_data_valid_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic [14:0] prg_address_o,
  output logic        prg_request_o,
  input  logic [7:0]  prg_data_i,
  input  logic        prg_ack_i,
  output logic [2:0]  ppu_address_o,
  output logic [7:0]  ppu_data_o,
  output logic        ppu_write_o,
  output logic        ppu_request_o,
  input  logic [7:0]  ppu_data_i,
  input  logic        ppu_ack_i
);
  typedef enum logic [1:0] {IDLE, LOCAL, EXT, DONE} state_t;
  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q;
  logic        served_q;
  logic [7:0]  open_bus_q, data_q, done_data, ext_rdata;
  logic [3:0]  wait_q;
  logic [7:0]  tmo_q;
  logic [7:0]  ram [0:2047];
  logic        lat_ram, lat_ppu, new_ext, capture, ext_ack, tmo_hit, local_fin, finish;

  assign lat_ram   = req_q.addr[15:13] == 3'b000;
  assign lat_ppu   = req_q.addr[15:13] == 3'b001;
  // PPU accesses and PRG reads go out on a req/ack handshake; everything else is served locally.
  assign new_ext   = (cpu_address_i[15:13] == 3'b001) || (cpu_address_i[15] && !cpu_data_valid_i);
  assign capture   = (state_q == IDLE || state_q == DONE) && cpu_address_valid_i &&
                     (!served_q || {cpu_address_i, cpu_data_valid_i} != {req_q.addr, req_q.wr});
  assign ext_ack   = (state_q == EXT) && (lat_ppu ? ppu_ack_i : prg_ack_i);
  assign ext_rdata = lat_ppu ? ppu_data_i : prg_data_i;
  assign tmo_hit   = tmo_q == 8'(EXT_TIMEOUT - 1);
  assign local_fin = (state_q == LOCAL) && (wait_q == 4'd0);
  assign finish    = local_fin || ((state_q == EXT) && (ext_ack || tmo_hit));

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (capture) state_d = new_ext ? EXT : LOCAL;
      LOCAL:      if (local_fin) state_d = DONE;
      EXT:        if (ext_ack || tmo_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_data_valid_o = (state_q == DONE) && served_q && cpu_address_valid_i &&
                       (cpu_address_i == req_q.addr);
    prg_request_o    = (state_q == EXT) && !lat_ppu;
    ppu_request_o    = (state_q == EXT) && lat_ppu;
  end

  // Writes always complete with their own data (even on a handshake timeout); reads that
  // time out or hit unmapped space fall back to the last value seen on the bus.
  always_comb begin
    done_data = open_bus_q;
    if (req_q.wr)                         done_data = req_q.wdata;
    else if (ext_ack)                     done_data = ext_rdata;
    else if (state_q == LOCAL && lat_ram) done_data = ram[req_q.addr[10:0]];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      req_q      <= '0;
      served_q   <= 1'b0;
      open_bus_q <= 8'h00;
      data_q     <= 8'h00;
      wait_q     <= 4'd0;
      tmo_q      <= 8'd0;
    end else begin
      if (capture) begin
        req_q    <= '{addr: cpu_address_i, wr: cpu_data_valid_i, wdata: cpu_data_i};
        served_q <= 1'b0;
        wait_q   <= 4'(RAM_WAIT_STATES);
        tmo_q    <= 8'd0;
      end
      if (state_q == LOCAL && wait_q != 4'd0) wait_q <= wait_q - 4'd1;
      if (state_q == EXT && !finish)          tmo_q  <= tmo_q + 8'd1;
      if (finish) begin
        served_q   <= 1'b1;
        data_q     <= done_data;
        open_bus_q <= done_data;
      end
    end
  end

  // RAM is only written on completion, so a reset mid-access leaves the array untouched.
  always_ff @(posedge clock_i) begin
    if (!reset_i && local_fin && req_q.wr && lat_ram) ram[req_q.addr[10:0]] <= req_q.wdata;
  end

  assign cpu_data_o    = data_q;
  assign prg_address_o = req_q.addr[14:0];
  assign ppu_address_o = req_q.addr[2:0];
  assign ppu_data_o    = req_q.wdata;
  assign ppu_write_o   = req_q.wr && lat_ppu;
endmodule

// File: tb/tb_cpu_bus.sv
// Bench for cpu_bus: directed walk through the main access types, then randomized traffic
// against a transaction-level model that tracks capture/completion edges by absolute cycle.
module tb_cpu_bus;
  localparam int W = 1;
  localparam int T = 4;
  localparam int R_RAM = 0, R_PPU = 1, R_UNM = 2, R_PRG = 3;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [15:0] cpu_address_i;
  logic        cpu_address_valid_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_data_valid_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_valid_o;
  logic [14:0] prg_address_o;
  logic        prg_request_o;
  logic [7:0]  prg_data_i;
  logic        prg_ack_i;
  logic [2:0]  ppu_address_o;
  logic [7:0]  ppu_data_o;
  logic        ppu_write_o;
  logic        ppu_request_o;
  logic [7:0]  ppu_data_i;
  logic        ppu_ack_i;

  cpu_bus #(.RAM_WAIT_STATES(W), .EXT_TIMEOUT(T)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .cpu_address_i(cpu_address_i), .cpu_address_valid_i(cpu_address_valid_i),
    .cpu_data_i(cpu_data_i), .cpu_data_valid_i(cpu_data_valid_i),
    .cpu_data_o(cpu_data_o), .cpu_data_valid_o(cpu_data_valid_o),
    .prg_address_o(prg_address_o), .prg_request_o(prg_request_o),
    .prg_data_i(prg_data_i), .prg_ack_i(prg_ack_i),
    .ppu_address_o(ppu_address_o), .ppu_data_o(ppu_data_o),
    .ppu_write_o(ppu_write_o), .ppu_request_o(ppu_request_o),
    .ppu_data_i(ppu_data_i), .ppu_ack_i(ppu_ack_i)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int failures = 0;

  // Model state
  bit          m_known = 0;
  bit          m_busy, m_done;
  logic [15:0] m_addr;
  bit          m_wr;
  logic [7:0]  m_wdata, m_data, m_ob;
  int          m_cap, edge_n = 0;
  logic [7:0]  mem [2048];

  function automatic int region(input logic [15:0] a);
    if (a < 16'h2000) return R_RAM;
    if (a < 16'h4000) return R_PPU;
    if (a < 16'h8000) return R_UNM;
    return R_PRG;
  endfunction

  function automatic bit is_ext(input logic [15:0] a, input bit wr);
    return region(a) == R_PPU || (region(a) == R_PRG && !wr);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic check_outputs();
    bit ext;
    int rg;
    rg  = region(m_addr);
    ext = m_busy && is_ext(m_addr, m_wr);
    chk("valid",    cpu_data_valid_o, m_done && cpu_address_valid_i && cpu_address_i == m_addr);
    chk("data",     cpu_data_o, m_data);
    chk("prg_req",  prg_request_o, ext && rg == R_PRG);
    chk("ppu_req",  ppu_request_o, ext && rg == R_PPU);
    chk("prg_addr", prg_address_o, m_addr % 32'h8000);
    chk("ppu_addr", ppu_address_o, m_addr % 8);
    chk("ppu_wr",   ppu_write_o, m_wr && rg == R_PPU);
    chk("ppu_data", ppu_data_o, m_wdata);
  endtask

  task automatic complete(input logic [7:0] rdata);
    logic [7:0] v;
    v = m_wr ? m_wdata : rdata;
    if (m_wr && region(m_addr) == R_RAM) mem[m_addr % 2048] = m_wdata;
    m_data = v;
    m_ob   = v;
    m_busy = 0;
    m_done = 1;
  endtask

  // Advance the model across one rising edge using the inputs presented this cycle.
  task automatic model_edge();
    edge_n++;
    if (reset_i) begin
      m_known = 1; m_busy = 0; m_done = 0;
      m_addr = 0; m_wr = 0; m_wdata = 0; m_data = 0; m_ob = 0;
    end else if (m_busy) begin
      if (!is_ext(m_addr, m_wr)) begin
        if (edge_n == m_cap + W + 1)
          complete(region(m_addr) == R_RAM ? mem[m_addr % 2048] : m_ob);
      end else if (region(m_addr) == R_PPU ? ppu_ack_i : prg_ack_i) begin
        complete(region(m_addr) == R_PPU ? ppu_data_i : prg_data_i);
      end else if (edge_n == m_cap + T) begin
        complete(m_ob);
      end
    end else if (cpu_address_valid_i &&
                 (!m_done || cpu_address_i != m_addr || cpu_data_valid_i != m_wr)) begin
      m_addr = cpu_address_i; m_wr = cpu_data_valid_i; m_wdata = cpu_data_i;
      m_busy = 1; m_done = 0; m_cap = edge_n;
    end
  endtask

  task automatic tick();
    #1;
    if (m_known) check_outputs();
    model_edge();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic req(input logic [15:0] a, input bit wr, input logic [7:0] d);
    cpu_address_i = a; cpu_data_valid_i = wr; cpu_data_i = d; cpu_address_valid_i = 1'b1;
  endtask

  logic [15:0] pool [16] = '{16'h0005, 16'h0805, 16'h1805, 16'h0010, 16'h07FF, 16'h1FFF,
                             16'h0123, 16'h0923, 16'h2000, 16'h2007, 16'h3FF9, 16'h4020,
                             16'h7FFF, 16'h8000, 16'hFFFC, 16'hC123};

  initial begin
    reset_i = 1'b1; cpu_address_i = '0; cpu_address_valid_i = 1'b0; cpu_data_i = '0;
    cpu_data_valid_i = 1'b0; prg_data_i = '0; prg_ack_i = 1'b0; ppu_data_i = '0; ppu_ack_i = 1'b0;
    @(negedge clock_i);
    tick(); tick();
    chk("rst_valid", cpu_data_valid_o, 0);
    chk("rst_data", cpu_data_o, 0);
    chk("rst_prg_req", prg_request_o, 0);
    chk("rst_ppu_wr", ppu_write_o, 0);
    reset_i = 1'b0;

    // RAM write then mirrored read
    req(16'h0005, 1, 8'h3C); tick(); tick();
    chk("ram_wr_early", cpu_data_valid_o, 0);
    tick();
    chk("ram_wr_valid", cpu_data_valid_o, 1);
    req(16'h0805, 0, 8'h00); tick(); tick();
    chk("ram_rd_early", cpu_data_valid_o, 0);
    tick();
    chk("ram_rd_valid", cpu_data_valid_o, 1);
    chk("ram_rd_data", cpu_data_o, 8'h3C);

    // PRG read, ack on the last cycle before timeout (ack wins)
    req(16'hFFFC, 0, 8'h00); tick();
    chk("prg_req_on", prg_request_o, 1);
    chk("prg_addr", prg_address_o, 15'h7FFC);
    tick(); tick(); tick();
    chk("prg_req_held", prg_request_o, 1);
    prg_ack_i = 1'b1; prg_data_i = 8'h00; tick(); prg_ack_i = 1'b0;
    chk("prg_valid", cpu_data_valid_o, 1);
    chk("prg_data", cpu_data_o, 8'h00);
    chk("prg_req_drop", prg_request_o, 0);

    req(16'hFFFD, 0, 8'h00); tick();
    prg_ack_i = 1'b1; prg_data_i = 8'h80; tick(); prg_ack_i = 1'b0;
    chk("prg2_data", cpu_data_o, 8'h80);
    tick(); tick(); tick();
    chk("repeat_no_refetch", prg_request_o, 0);
    chk("repeat_valid", cpu_data_valid_o, 1);

    // PPU write, mirrored register
    req(16'h2008, 1, 8'h90); tick();
    chk("ppu_req_on", ppu_request_o, 1);
    chk("ppu_addr", ppu_address_o, 0);
    chk("ppu_wr", ppu_write_o, 1);
    chk("ppu_wdata", ppu_data_o, 8'h90);
    tick(); tick();
    chk("ppu_req_held", ppu_request_o, 1);
    ppu_ack_i = 1'b1; ppu_data_i = 8'h55; tick(); ppu_ack_i = 1'b0;
    chk("ppu_valid", cpu_data_valid_o, 1);
    chk("ppu_done_data", cpu_data_o, 8'h90);
    chk("ppu_req_drop", ppu_request_o, 0);

    // PRG read with no ack times out to open bus
    req(16'h8123, 0, 8'h00); tick(); tick(); tick(); tick();
    chk("tmo_req_held", prg_request_o, 1);
    tick();
    chk("tmo_req_drop", prg_request_o, 0);
    chk("tmo_valid", cpu_data_valid_o, 1);
    chk("tmo_data", cpu_data_o, 8'h90);

    // Unmapped read returns the last RAM read value
    req(16'h0010, 1, 8'h5A); tick(); tick(); tick();
    req(16'h0010, 0, 8'h00); tick(); tick(); tick();
    req(16'h4020, 0, 8'h00); tick(); tick();
    chk("unm_early", cpu_data_valid_o, 0);
    tick();
    chk("unm_valid", cpu_data_valid_o, 1);
    chk("unm_data", cpu_data_o, 8'h5A);

    // Address change in DONE drops valid immediately, new request next cycle
    req(16'h8000, 0, 8'h00); tick();
    prg_ack_i = 1'b1; prg_data_i = 8'h11; tick(); prg_ack_i = 1'b0;
    chk("chg_valid_before", cpu_data_valid_o, 1);
    cpu_address_i = 16'h8001; #1;
    chk("chg_valid_drop", cpu_data_valid_o, 0);
    tick();
    chk("chg_new_req", prg_request_o, 1);
    chk("chg_new_addr", prg_address_o, 15'h0001);

    // Reset in the middle of a PRG access
    reset_i = 1'b1; tick();
    chk("rst_mid_req", prg_request_o, 0);
    chk("rst_mid_valid", cpu_data_valid_o, 0);
    reset_i = 1'b0;

    // Seed RAM indices not yet written so random reads are well defined
    req(16'h07FF, 1, 8'hA7); tick(); tick(); tick();
    req(16'h0123, 1, 8'h23); tick(); tick(); tick();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        cpu_address_i    = pool[$urandom_range(15)];
        cpu_data_valid_i = ($urandom_range(2) == 0);
        cpu_data_i       = 8'($urandom);
      end
      cpu_address_valid_i = ($urandom_range(9) != 0);
      reset_i    = ($urandom_range(399) == 0);
      prg_ack_i  = ($urandom_range(9) < 3);
      prg_data_i = 8'($urandom);
      ppu_ack_i  = ($urandom_range(9) < 3);
      ppu_data_i = 8'($urandom);
      tick();
    end

    reset_i = 1'b0; prg_ack_i = 1'b0; ppu_ack_i = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
